memctrl: RTL and testbench
==========================

# memctrl

Byte-wide memory controller between the pipeline and the single-port synchronous RAM. It serves two clients:
- the fetch stage, as one pipelined byte read per cycle;
- the MEM stage, as 1–4 byte loads and stores.

MEM has absolute priority. Every issued RAM read carries a tag through a 2-deep return pipeline, so fetch bytes already in flight still return correctly while MEM starts, and a branch flush can drop them.

## Interface
No parameters.
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- if_flag_i  in  1  fetch requests the byte at if_addr_i this cycle
- if_addr_i  in  32  fetch byte address
- if_flush_i  in  1  branch taken; discard all fetch bytes in flight
- if_r_o  out  1  fetch byte valid this cycle
- if_data_o  out  8  returned fetch byte
- mem_rw_i  in  2  00 none, 01 load, 10 store, 11 treated as 00
- mem_addr_i  in  32  load/store base byte address
- mem_len_i  in  3  byte count; 1..4 honoured, 0 or >4 treated as 4
- mem_data_i  in  32  store data, byte k = bits [8k+7:8k]
- mem_done_o  out  1  one-cycle completion pulse
- mem_data_o  out  32  load result, little-endian, unused upper bytes zero
- ram_addr_o  out  32  RAM byte address
- ram_wr_o  out  1  1 = write ram_data_o at ram_addr_o
- ram_data_o  out  8  RAM write byte
- ram_data_i  in  8  RAM read byte; valid one edge after the address edge

## Operation
- All outputs are registered.
- Reset values: every output is 0, FSM is IDLE, tag pipeline is empty, byte counters are 0.
- Tag pipeline t1→t2. Each tag is one of NONE, IF, or MEM(k) (MEM byte index k).
  - An address issued at edge E loads t1 at E and moves to t2 at E+1.
  - At E+2, t2 selects the destination of ram_data_i:
    - IF: set if_r_o=1, if_data_o=ram_data_i;
    - MEM(k): write mem_data_o[8k+7:8k];
    - NONE: if_r_o=0.
- if_flush_i=1 at an edge:
  - forces t1 and t2 IF tags to NONE;
  - forces if_r_o←0 at that edge;
  - does not affect MEM tags or the FSM.
- FSM states: IDLE, MRD, MWR, MWAIT, MDONE.
- IDLE:
  - mem_rw_i=01: latch addr and len, clear mem_data_o, issue byte 0 (ram_wr_o=0), k=1. Next state is MWAIT if len=1, else MRD.
  - mem_rw_i=10: issue write of byte 0 (ram_wr_o=1, ram_data_o=mem_data_i[7:0]), k=1. Next state is MDONE-pending if len=1, else MWR.
  - Otherwise, if if_flag_i=1: issue ram_addr_o=if_addr_i with ram_wr_o=0 and tag IF.
  - Otherwise: issue nothing; tag is NONE.
  - Simultaneous MEM request and if_flag_i: MEM wins and the fetch request is dropped, not queued.
- MRD: issue addr+k with tag MEM(k), k++. After byte len-1 is issued, go to MWAIT.
- MWR: write addr+k with byte k of the latched store data, k++. On the edge after the last write: ram_wr_o←0, mem_done_o←1, go to MDONE.
- MWAIT: issue nothing. On the edge that captures the last MEM byte: mem_done_o←1, go to MDONE. mem_data_o is complete in that same cycle.
- MDONE: mem_done_o←0 and go to IDLE. No request from either client is accepted at this edge.
- Fetch requests are ignored in every state except IDLE.
- Address arithmetic is 32-bit with wrap at 0xFFFFFFFF→0.
- Load data is always zero-extended; sign extension is done by MEM.

## Timing
- Fetch: request sampled at E → if_r_o=1 in the cycle after E+2. Throughput is 1 byte/cycle.
- Load of len L accepted at E: bytes issued at E..E+L-1. mem_done_o is high in exactly one cycle, after E+L+1.
- Store of len L accepted at E: writes at E..E+L-1. mem_done_o is high in the cycle after E+L.
- After mem_done_o: the earliest new MEM accept is 2 edges after the done-setting edge.
- Fetch bytes issued before a MEM accept still return with correct data, interleaved ahead of MEM bytes.
- Reset asserted mid-transaction: immediate return to reset values. No partial done pulse; in-flight tags are lost.

## Test plan
- Reset with rst=1 mid-load → all outputs 0 immediately. After release, IDLE accepts on the first edge.
- Fetch bursts addr 0x100..0x103, RAM bytes 13,00,00,93 → four if_r_o pulses on consecutive cycles with 0x13,0x00,0x00,0x93. The first pulse comes 2 edges after the first request.
- Load len=4 at 0x200, RAM bytes 78,56,34,12 → mem_data_o=0x12345678 with mem_done_o for exactly 1 cycle, after E+5. The next request is not accepted at the MDONE edge.
- Store len=2 of 0xAABBCCDD at 0x300 → ram_wr_o=1 writing 0xDD@0x300 then 0xCC@0x301. mem_done_o pulses 1 cycle; 0xBB and 0xAA are never written.
- Two fetch bytes in flight, then if_flush_i=1 → no if_r_o for those bytes. A new fetch issued next returns normally.
- if_flag_i and load len=1 in the same cycle → only the MEM address is issued. No if_r_o results; mem_done_o follows at E+2.

Source files
------------

// File: rtl/memctrl.sv
// Byte-wide RAM controller: pipelined fetch reads plus 1-4 byte MEM loads/stores,
// with a two-stage tag pipeline steering each returning RAM byte to its client.
module memctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_flag_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic        if_r_o,
    output logic [7:0]  if_data_o,
    input  logic [1:0]  mem_rw_i,
    input  logic [31:0] mem_addr_i,
    input  logic [2:0]  mem_len_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_done_o,
    output logic [31:0] mem_data_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    output logic [7:0]  ram_data_o,
    input  logic [7:0]  ram_data_i
);

    typedef enum logic [2:0] {
        IDLE,
        MRD,
        MWR,
        MWAIT,
        MDONE
    } state_t;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_MEM
    } tag_kind_t;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [2:0]  len_reg;
    logic [2:0]  k_reg;
    logic [31:0] store_data_reg;
    tag_kind_t   t1_kind_reg;
    logic [1:0]  t1_idx_reg;
    tag_kind_t   t2_kind_reg;
    logic [1:0]  t2_idx_reg;

    logic [2:0]  len_eff;
    logic        load_accept;
    logic        store_accept;
    logic        capture_if;
    logic        capture_mem;
    logic        last_mem;
    logic [31:0] mem_data_next;
    logic [31:0] next_addr;

    // Lengths outside 1..4 behave as a full word.
    assign len_eff      = (mem_len_i == 3'd0 || mem_len_i > 3'd4) ? 3'd4 : mem_len_i;
    assign load_accept  = (state_reg == IDLE) && (mem_rw_i == 2'b01);
    assign store_accept = (state_reg == IDLE) && (mem_rw_i == 2'b10);
    assign capture_if   = (t2_kind_reg == TAG_IF) && !if_flush_i;
    assign capture_mem  = (t2_kind_reg == TAG_MEM);
    assign last_mem     = capture_mem && ({1'b0, t2_idx_reg} == len_reg - 3'd1);
    assign next_addr    = addr_reg + {29'd0, k_reg};

    // A returning MEM byte lands in its lane; a new load starts from zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_data_next[8*gi +: 8] =
                (capture_mem && t2_idx_reg == 2'(gi)) ? ram_data_i :
                (load_accept ? 8'h00 : mem_data_o[8*gi +: 8]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= 32'd0;
            len_reg        <= 3'd0;
            k_reg          <= 3'd0;
            store_data_reg <= 32'd0;
            t1_kind_reg    <= TAG_NONE;
            t1_idx_reg     <= 2'd0;
            t2_kind_reg    <= TAG_NONE;
            t2_idx_reg     <= 2'd0;
            if_r_o         <= 1'b0;
            if_data_o      <= 8'd0;
            mem_done_o     <= 1'b0;
            mem_data_o     <= 32'd0;
            ram_addr_o     <= 32'd0;
            ram_wr_o       <= 1'b0;
            ram_data_o     <= 8'd0;
        end else begin
            if_r_o     <= capture_if;
            if (capture_if) begin
                if_data_o <= ram_data_i;
            end
            mem_data_o <= mem_data_next;

            // A flush kills fetch tags in both stages; MEM tags are untouched.
            t2_kind_reg <= (if_flush_i && t1_kind_reg == TAG_IF) ? TAG_NONE : t1_kind_reg;
            t2_idx_reg  <= t1_idx_reg;
            t1_kind_reg <= TAG_NONE;
            t1_idx_reg  <= 2'd0;

            case (state_reg)
                IDLE: begin
                    if (load_accept) begin
                        addr_reg    <= mem_addr_i;
                        len_reg     <= len_eff;
                        k_reg       <= 3'd1;
                        ram_addr_o  <= mem_addr_i;
                        ram_wr_o    <= 1'b0;
                        t1_kind_reg <= TAG_MEM;
                        t1_idx_reg  <= 2'd0;
                        state_reg   <= (len_eff == 3'd1) ? MWAIT : MRD;
                    end else if (store_accept) begin
                        addr_reg       <= mem_addr_i;
                        len_reg        <= len_eff;
                        store_data_reg <= mem_data_i;
                        k_reg          <= 3'd1;
                        ram_addr_o     <= mem_addr_i;
                        ram_wr_o       <= 1'b1;
                        ram_data_o     <= mem_data_i[7:0];
                        state_reg      <= MWR;
                    end else if (if_flag_i) begin
                        ram_addr_o  <= if_addr_i;
                        ram_wr_o    <= 1'b0;
                        t1_kind_reg <= if_flush_i ? TAG_NONE : TAG_IF;
                    end else begin
                        ram_wr_o <= 1'b0;
                    end
                end

                MRD: begin
                    ram_addr_o  <= next_addr;
                    ram_wr_o    <= 1'b0;
                    t1_kind_reg <= TAG_MEM;
                    t1_idx_reg  <= k_reg[1:0];
                    k_reg       <= k_reg + 3'd1;
                    if (k_reg == len_reg - 3'd1) begin
                        state_reg <= MWAIT;
                    end
                end

                // A single-byte store arrives here with k already equal to len.
                MWR: begin
                    if (k_reg < len_reg) begin
                        ram_addr_o <= next_addr;
                        ram_wr_o   <= 1'b1;
                        ram_data_o <= store_data_reg[{k_reg[1:0], 3'b000} +: 8];
                        k_reg      <= k_reg + 3'd1;
                    end else begin
                        ram_wr_o   <= 1'b0;
                        mem_done_o <= 1'b1;
                        state_reg  <= MDONE;
                    end
                end

                MWAIT: begin
                    ram_wr_o <= 1'b0;
                    if (last_mem) begin
                        mem_done_o <= 1'b1;
                        state_reg  <= MDONE;
                    end
                end

                MDONE: begin
                    ram_wr_o   <= 1'b0;
                    mem_done_o <= 1'b0;
                    state_reg  <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memctrl.sv
// Directed bench for memctrl: a registered-read byte RAM model and
// hand-computed expectations for fetch, load, store, flush and reset cases.
module tb_memctrl;

    logic        clk;
    logic        rst;
    logic        if_flag;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_r;
    logic [7:0]  if_data;
    logic [1:0]  mem_rw;
    logic [31:0] mem_addr;
    logic [2:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_q;

    logic [7:0]  ram [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;
    logic [7:0]  fexp [4];

    int check_count;
    int pass_count;

    memctrl dut (
        .clk        (clk),
        .rst        (rst),
        .if_flag_i  (if_flag),
        .if_addr_i  (if_addr),
        .if_flush_i (if_flush),
        .if_r_o     (if_r),
        .if_data_o  (if_data),
        .mem_rw_i   (mem_rw),
        .mem_addr_i (mem_addr),
        .mem_len_i  (mem_len),
        .mem_data_i (mem_wdata),
        .mem_done_o (mem_done),
        .mem_data_o (mem_rdata),
        .ram_addr_o (ram_addr),
        .ram_wr_o   (ram_wr),
        .ram_data_o (ram_wdata),
        .ram_data_i (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: data for the address presented at edge N appears after edge N+1.
    always @(posedge clk) begin
        if (ram_wr) begin
            ram[ram_addr[11:0]] <= ram_wdata;
        end else if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end
        ram_q <= ram[ram_addr[11:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_if_r"},     {31'd0, if_r},     32'd0);
        check({tag, "_if_data"},  {24'd0, if_data},  32'd0);
        check({tag, "_done"},     {31'd0, mem_done}, 32'd0);
        check({tag, "_mem_data"}, mem_rdata,         32'd0);
        check({tag, "_ram_addr"}, ram_addr,          32'd0);
        check({tag, "_ram_wr"},   {31'd0, ram_wr},   32'd0);
        check({tag, "_ram_data"}, {24'd0, ram_wdata}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst       = 1'b1;
        if_flag   = 1'b0;
        if_addr   = 32'd0;
        if_flush  = 1'b0;
        mem_rw    = 2'b00;
        mem_addr  = 32'd0;
        mem_len   = 3'd0;
        mem_wdata = 32'd0;
        pre_we    = 1'b0;
        pre_addr  = 12'd0;
        pre_data  = 8'd0;
        fexp[0] = 8'h13; fexp[1] = 8'h00; fexp[2] = 8'h00; fexp[3] = 8'h93;

        preload(12'h100, 8'h13); preload(12'h101, 8'h00);
        preload(12'h102, 8'h00); preload(12'h103, 8'h93);
        preload(12'h200, 8'h78); preload(12'h201, 8'h56);
        preload(12'h202, 8'h34); preload(12'h203, 8'h12);
        preload(12'h302, 8'hEE); preload(12'h303, 8'hEF);
        preload(12'h180, 8'hA1); preload(12'h181, 8'hA2);
        preload(12'h190, 8'h5C); preload(12'h400, 8'h3E);
        preload(12'h404, 8'hC4); preload(12'hFFF, 8'h11);
        preload(12'h000, 8'h22);
        check_all_zero("reset");
        rst = 1'b0;

        // Fetch burst 0x100..0x103
        for (int i = 0; i < 8; i++) begin
            if_flag = (i < 4);
            if_addr = 32'h100 + i;
            tick();
            if (i == 0) check("fetch_addr0", ram_addr, 32'h100);
            if (i >= 2 && i < 6) begin
                check("fetch_valid", {31'd0, if_r}, 32'd1);
                check("fetch_data", {24'd0, if_data}, {24'd0, fexp[i-2]});
            end else begin
                check("fetch_idle", {31'd0, if_r}, 32'd0);
            end
        end
        if_flag = 1'b0;

        // Load len 4 at 0x200, then a len-1 load held across the MDONE edge
        mem_rw = 2'b01; mem_addr = 32'h200; mem_len = 3'd4;
        for (int n = 0; n <= 10; n++) begin
            if (n == 1) mem_rw = 2'b00;
            if (n == 6) begin mem_rw = 2'b01; mem_addr = 32'h400; mem_len = 3'd1; end
            if (n == 8) mem_rw = 2'b00;
            tick();
            check("ld_done", {31'd0, mem_done}, {31'd0, (n == 5 || n == 9)});
            if (n <= 3) check("ld_addr", ram_addr, 32'h200 + n);
            if (n == 1) check("ld_wr", {31'd0, ram_wr}, 32'd0);
            if (n == 5) check("ld_data", mem_rdata, 32'h12345678);
            if (n == 6) check("ld_mdone_hold", ram_addr, 32'h203);
            if (n == 7) begin
                check("ld2_addr", ram_addr, 32'h400);
                check("ld2_clear", mem_rdata, 32'd0);
            end
            if (n == 9) check("ld2_data", mem_rdata, 32'h3E);
        end

        // Store len 2 of 0xAABBCCDD at 0x300
        mem_rw = 2'b10; mem_addr = 32'h300; mem_len = 3'd2; mem_wdata = 32'hAABBCCDD;
        for (int n = 0; n <= 3; n++) begin
            if (n == 1) mem_rw = 2'b00;
            tick();
            check("st_done", {31'd0, mem_done}, {31'd0, (n == 2)});
            check("st_wr", {31'd0, ram_wr}, {31'd0, (n < 2)});
            if (n == 0) begin
                check("st_addr0", ram_addr, 32'h300);
                check("st_byte0", {24'd0, ram_wdata}, 32'hDD);
            end
            if (n == 1) begin
                check("st_addr1", ram_addr, 32'h301);
                check("st_byte1", {24'd0, ram_wdata}, 32'hCC);
            end
        end
        check("st_ram300", {24'd0, ram[12'h300]}, 32'hDD);
        check("st_ram301", {24'd0, ram[12'h301]}, 32'hCC);
        check("st_ram302", {24'd0, ram[12'h302]}, 32'hEE);
        check("st_ram303", {24'd0, ram[12'h303]}, 32'hEF);

        // Flush two fetch bytes in flight, then fetch 0x190
        for (int n = 0; n <= 6; n++) begin
            if_flag  = (n == 0 || n == 1 || n == 3);
            if_addr  = (n == 3) ? 32'h190 : 32'h180 + n;
            if_flush = (n == 2);
            tick();
            if (n == 5) begin
                check("flush_new_valid", {31'd0, if_r}, 32'd1);
                check("flush_new_data", {24'd0, if_data}, 32'h5C);
            end else begin
                check("flush_quiet", {31'd0, if_r}, 32'd0);
            end
        end
        if_flag = 1'b0; if_flush = 1'b0;

        // Fetch and len-1 load in the same cycle: MEM wins
        if_flag = 1'b1; if_addr = 32'h100;
        mem_rw = 2'b01; mem_addr = 32'h404; mem_len = 3'd1;
        for (int n = 0; n <= 3; n++) begin
            if (n == 1) begin if_flag = 1'b0; mem_rw = 2'b00; end
            tick();
            if (n == 0) check("both_addr", ram_addr, 32'h404);
            check("both_no_if", {31'd0, if_r}, 32'd0);
            check("both_done", {31'd0, mem_done}, {31'd0, (n == 2)});
            if (n == 2) check("both_data", mem_rdata, 32'hC4);
        end

        // len = 0 behaves as 4
        mem_rw = 2'b01; mem_addr = 32'h200; mem_len = 3'd0;
        for (int n = 0; n <= 6; n++) begin
            if (n == 1) mem_rw = 2'b00;
            tick();
            check("len0_done", {31'd0, mem_done}, {31'd0, (n == 5)});
            if (n == 5) check("len0_data", mem_rdata, 32'h12345678);
        end

        // Address wrap 0xFFFFFFFF -> 0
        mem_rw = 2'b01; mem_addr = 32'hFFFFFFFF; mem_len = 3'd2;
        for (int n = 0; n <= 4; n++) begin
            if (n == 1) mem_rw = 2'b00;
            tick();
            if (n == 1) check("wrap_addr", ram_addr, 32'h0);
            check("wrap_done", {31'd0, mem_done}, {31'd0, (n == 3)});
            if (n == 3) check("wrap_data", mem_rdata, 32'h2211);
        end

        // Reset asserted in the middle of a load
        mem_rw = 2'b01; mem_addr = 32'h200; mem_len = 3'd4;
        for (int n = 0; n <= 3; n++) begin
            if (n == 1) mem_rw = 2'b00;
            tick();
        end
        check("rst_partial", mem_rdata, 32'h5678);
        rst = 1'b1;
        #2;
        check_all_zero("rst_mid");
        tick();
        tick();
        rst = 1'b0;
        mem_rw = 2'b01; mem_addr = 32'h404; mem_len = 3'd1;
        for (int n = 0; n <= 3; n++) begin
            if (n == 1) mem_rw = 2'b00;
            tick();
            if (n == 0) check("post_rst_addr", ram_addr, 32'h404);
            check("post_rst_done", {31'd0, mem_done}, {31'd0, (n == 2)});
            if (n == 2) check("post_rst_data", mem_rdata, 32'hC4);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
